pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Stall/flush sequencer for the 5-stage pipeline. Consumes decode-stage register-read info and
//  EX/MEM control bits produced by the control unit. Drives per-stage stall/flush for three cases:
//   - load-use RAW hazards
//   - multi-cycle multiply occupancy of EX
//   - taken branch/jump redirects
// PARAMETERS
//  MUL_LATENCY   4   cycles a MUL occupies EX, first cycle included; legal range 2..16
// PORTS
//  clk             in   1  pipeline clock, rising edge
//  rst             in   1  asynchronous, active-high reset
//  rs1_d           in   5  decode-stage source register 1
//  rs2_d           in   5  decode-stage source register 2
//  reg_read_en_d   in   2  [0]=rs1 used, [1]=rs2 used
//  rd_e            in   5  EX-stage destination register
//  reg_write_en_e  in   1  EX instruction writes rd
//  dmem_read_en_e  in   1  EX instruction is a load
//  mul_en_e        in   1  EX instruction is a MUL
//  rd_m            in   5  MEM-stage destination register
//  reg_write_en_m  in   1  MEM instruction writes rd
//  redirect_e      in   1  EX resolved taken branch / JAL / JALR
//  stall_f         out  1  hold PC
//  stall_d         out  1  hold IF/ID register
//  stall_e         out  1  hold ID/EX register (MUL in progress)
//  flush_d         out  1  clear IF/ID to NOP
//  flush_e         out  1  clear ID/EX to NOP
//  flush_m         out  1  insert bubble into EX/MEM
//  mul_start       out  1  one-cycle start pulse to multiplier
//  mul_busy        out  1  multiplier occupying EX
// BEHAVIOUR
//  - While rst is high, all outputs are 0, the FSM is in RUN and cnt is 0.
//  - Outputs are combinational from state, cnt and inputs (zero-cycle response).
//    State and cnt are registered.
//  - Register x0 never creates a hazard. A source only matches if its reg_read_en_d bit is set.
//  - Load-use: dmem_read_en_e & reg_write_en_e & rd_e!=0 & match(rs_d, rd_e)
//    -> stall_f=stall_d=1, flush_e=1 for exactly one cycle.
//  - FSM RUN:
//    - mul_en_e=1 -> mul_start=1, mul_busy=1, stall_f=stall_d=stall_e=1, flush_m=1;
//      cnt<=MUL_LATENCY-2; next state MUL_BUSY.
//  - FSM MUL_BUSY:
//    - cnt!=0: mul_busy=1, stall_f/d/e=1, flush_m=1; cnt<=cnt-1.
//    - cnt==0 (final cycle): mul_busy=0 and stall_e=0, so the MUL advances; next state RUN.
//      Load-use and RAW checks apply normally in this cycle.
//  - Total EX occupancy is MUL_LATENCY cycles. Back-to-back MULs re-enter MUL_BUSY the cycle
//    after RUN resumes.
//  - Priority, highest first:
//    1. rst
//    2. redirect_e: flush_d=flush_e=1, stall_f=stall_d=0, which overrides a load-use stall.
//    3. MUL_BUSY stall: flush_e=0 while stall_e=1; a decode hazard only holds F/D.
//    4. Load-use / RAW stall.
//  - redirect_e and mul_en_e are mutually exclusive by decode. If both are asserted, redirect_e wins
//    and the MUL sequence does not start.
//  - Reset mid-MUL: the FSM returns asynchronously to RUN with cnt=0, and no mul_start is re-issued.
// CONFIGURATION
//  Macro HAZARD_FWD_EN selects how non-load RAW hazards are handled.
//  - Defined: the EX->D and MEM->D forwarding network exists. Only load-use stalls as specified above.
//  - Undefined: no forwarding.
//    - Any RAW against the EX writer (reg_write_en_e, rd_e!=0) or the MEM writer
//      (reg_write_en_m, rd_m!=0) asserts stall_f=stall_d=flush_e=1.
//    - The stall repeats each cycle until no match remains.
// STRUCTURE
//  - Package hazard_pkg: hz_state_t enum {RUN, MUL_BUSY}; MUL_CNT_W=$clog2(16); localparam REG_X0=5'd0.
//  - Sub-module mul_occupancy_cnt: down-counter plus RUN/MUL_BUSY FSM; outputs mul_busy and last.
//  - Top level: hazard comparators and priority muxing.
// TESTING
//  1. rst=1 mid-MUL (cnt=1) -> all outputs 0; after release, state RUN and no mul_start.
//  2. lw x5 in EX, add x6,x5,x7 in D (reg_read_en_d=11) -> one cycle of stall_f=stall_d=flush_e=1,
//     then 0.
//  3. mul_en_e=1, MUL_LATENCY=4 -> mul_start for 1 cycle; stall_e/mul_busy/flush_m high 3 cycles;
//     released on cycle 4.
//  4. lw x0 in EX, D reads x0 -> no stall. D reads x5 with reg_read_en_d=00 -> no stall.
//  5. redirect_e=1 together with load-use match -> flush_d=flush_e=1, stall_f=stall_d=0.
//  6. Without HAZARD_FWD_EN: add x3 in MEM, D reads x3 -> stall for 1 cycle.
//     With HAZARD_FWD_EN -> no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } hz_state_t;

    localparam int         MUL_CNT_W = $clog2(16);
    localparam logic [4:0] REG_X0    = 5'd0;

    // A decode source hits a producer only if it is actually read and the producer is not x0.
    function automatic logic src_hit(input logic [4:0] rs, input logic used, input logic [4:0] rd);
        return used && (rs == rd) && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/mul_occupancy_cnt.sv
// Tracks how long a MUL holds EX: RUN/MUL_BUSY FSM with a down-counter of remaining busy cycles.
module mul_occupancy_cnt
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_req,
    output logic mul_start,
    output logic mul_busy,
    output logic last
);

    hz_state_t              state_r, state_nxt_s;
    logic [MUL_CNT_W-1:0]   cnt_r, cnt_nxt_s;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= {MUL_CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state, counter update and occupancy outputs.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mul_start   = 1'b0;
        mul_busy    = 1'b0;
        last        = 1'b0;
        case (state_r)
            RUN: begin
                if (start_req) begin
                    mul_start   = 1'b1;
                    mul_busy    = 1'b1;
                    cnt_nxt_s   = MUL_CNT_W'(MUL_LATENCY - 2);
                    state_nxt_s = MUL_BUSY;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MUL_BUSY: begin
                if (cnt_r != {MUL_CNT_W{1'b0}}) begin
                    mul_busy  = 1'b1;
                    cnt_nxt_s = cnt_r - MUL_CNT_W'(1);
                end else begin
                    // Final cycle: the MUL leaves EX, so EX is no longer held.
                    last        = 1'b1;
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = {MUL_CNT_W{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use, MUL occupancy and redirect handling for the 5-stage pipeline.
// Define HAZARD_FWD_EN when the EX/MEM->D forwarding network exists (only load-use then stalls).
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [1:0] reg_read_en_d,
    input  logic [4:0] rd_e,
    input  logic       reg_write_en_e,
    input  logic       dmem_read_en_e,
    input  logic       mul_en_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_en_m,
    input  logic       redirect_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       mul_start,
    output logic       mul_busy
);

    logic hit_e_s, hit_m_s, load_use_s, hazard_s, hz_check_s;
    logic mul_start_s, mul_busy_s, last_s;

    mul_occupancy_cnt #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_occ (
        .clk       (clk),
        .rst       (rst),
        .start_req (mul_en_e & ~redirect_e),
        .mul_start (mul_start_s),
        .mul_busy  (mul_busy_s),
        .last      (last_s)
    );

    assign hit_e_s = reg_write_en_e &
                     (src_hit(rs1_d, reg_read_en_d[0], rd_e) | src_hit(rs2_d, reg_read_en_d[1], rd_e));
    assign hit_m_s = reg_write_en_m &
                     (src_hit(rs1_d, reg_read_en_d[0], rd_m) | src_hit(rs2_d, reg_read_en_d[1], rd_m));

    assign load_use_s = dmem_read_en_e & hit_e_s;

`ifdef HAZARD_FWD_EN
    assign hazard_s = load_use_s;
`else
    assign hazard_s = load_use_s | hit_e_s | hit_m_s;
`endif

    // Decode hazards are evaluated whenever EX is free, including the MUL's final cycle.
    assign hz_check_s = last_s | ~mul_busy_s;

    // Priority mux: reset, redirect, MUL occupancy, decode hazard.
    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        mul_start = 1'b0;
        mul_busy  = 1'b0;
        if (rst) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
        end else begin
            mul_start = mul_start_s;
            mul_busy  = mul_busy_s;
            stall_e   = mul_busy_s;
            flush_m   = mul_busy_s;
            if (redirect_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (mul_busy_s) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
            end else if (hz_check_s && hazard_s) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                flush_e = 1'b0;
            end
        end
    end

endmodule
